// File: rtl/lcd_text_console_if.sv
// Character-stream and LCD MMIO write-port bundle for lcd_text_console.
// The console is the slave on the character stream and the master on the MMIO port.
interface lcd_text_console_if;
    logic [7:0]  ch_data;
    logic        ch_valid;
    logic        ch_ready;
    logic [7:0]  attr;
    logic [15:0] mmio_addr;
    logic [7:0]  mmio_data;
    logic        mmio_req;
    logic        mmio_done;

    modport master (
        output ch_data, ch_valid, attr, mmio_done,
        input  ch_ready, mmio_addr, mmio_data, mmio_req
    );

    modport slave (
        input  ch_data, ch_valid, attr, mmio_done,
        output ch_ready, mmio_addr, mmio_data, mmio_req
    );
endinterface

// File: rtl/lcd_text_console.sv
// Terminal-style sequencer turning a byte stream into ASCII/attribute writes into LCD text VRAM.
// Optional macro LCD_CONSOLE_CLEAR_ROW_EN: blank the newly entered row on every row change.
`ifndef MMIO_ADDR_LCD
`define MMIO_ADDR_LCD 16'h8000
`endif

//  state   | meaning
//  IDLE    | waiting for a byte, ch_ready high
//  DECODE  | classify latched byte (printable / CR / LF / FF / ignored)
//  WR_LO   | ASCII byte write in flight, waiting for mmio_done
//  WR_HI   | attribute byte write in flight, waiting for mmio_done
//  GAP     | one idle cycle with mmio_req low between writes
//  ADVANCE | move cursor one cell right, wrapping column then row
//  CLEAR   | issue the next blank cell, or finish the fill
module lcd_text_console #(
    parameter int          COLS      = 60,
    parameter int          ROWS      = 17,
    parameter logic [15:0] BASE_ADDR = `MMIO_ADDR_LCD
) (
    input  logic                clock,
    input  logic                reset,
    lcd_text_console_if.slave   bus,
    output logic [5:0]          cursor_col,
    output logic [4:0]          cursor_row,
    output logic                busy
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_DECODE  = 3'd1;
    localparam logic [2:0] S_WR_LO   = 3'd2;
    localparam logic [2:0] S_WR_HI   = 3'd3;
    localparam logic [2:0] S_GAP     = 3'd4;
    localparam logic [2:0] S_ADVANCE = 3'd5;
    localparam logic [2:0] S_CLEAR   = 3'd6;

    localparam logic [5:0]  COL_LAST = 6'(COLS - 1);
    localparam logic [4:0]  ROW_LAST = 5'(ROWS - 1);
    localparam logic [10:0] COLS_W   = 11'(COLS);
    localparam logic [10:0] CELLS    = 11'(COLS * ROWS);

    logic [2:0]  state;
    logic [2:0]  after_gap;
    logic [7:0]  ch_q;
    logic [7:0]  attr_q;
    logic [10:0] idx;
    logic [10:0] end_idx;
    logic        clearing;
    logic        clear_full;
    logic [5:0]  col;
    logic [4:0]  row;
    logic [4:0]  row_next;
    logic [15:0] addr_r;
    logic [7:0]  data_r;
    logic        req_r;

    function automatic logic [10:0] cell_index(input logic [4:0] r, input logic [5:0] c);
        return 11'(r) * COLS_W + 11'(c);
    endfunction

    function automatic logic [15:0] cell_addr(input logic [10:0] i);
        return BASE_ADDR + {4'b0000, i, 1'b0};
    endfunction

    assign row_next = (row == ROW_LAST) ? 5'd0 : row + 5'd1;

`ifdef LCD_CONSOLE_CLEAR_ROW_EN
    logic [10:0] row_base;
    assign row_base = cell_index(row_next, 6'd0);
`endif

    assign bus.ch_ready  = (state == S_IDLE);
    assign bus.mmio_addr = addr_r;
    assign bus.mmio_data = data_r;
    assign bus.mmio_req  = req_r;
    assign busy          = (state != S_IDLE);
    assign cursor_col    = col;
    assign cursor_row    = row;

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_IDLE;
            after_gap  <= S_IDLE;
            ch_q       <= 8'h00;
            attr_q     <= 8'h00;
            idx        <= 11'd0;
            end_idx    <= 11'd0;
            clearing   <= 1'b0;
            clear_full <= 1'b0;
            col        <= 6'd0;
            row        <= 5'd0;
            addr_r     <= 16'h0000;
            data_r     <= 8'h00;
            req_r      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.ch_valid) begin
                        ch_q   <= bus.ch_data;
                        attr_q <= bus.attr;
                        state  <= S_DECODE;
                    end
                end

                S_DECODE: begin
                    if (ch_q >= 8'h20 && ch_q <= 8'h7E) begin
                        idx    <= cell_index(row, col);
                        addr_r <= cell_addr(cell_index(row, col));
                        data_r <= ch_q;
                        req_r  <= 1'b1;
                        state  <= S_WR_LO;
                    end else if (ch_q == 8'h0D) begin
                        col   <= 6'd0;
                        state <= S_IDLE;
                    end else if (ch_q == 8'h0A) begin
                        col <= 6'd0;
                        row <= row_next;
`ifdef LCD_CONSOLE_CLEAR_ROW_EN
                        idx        <= row_base;
                        end_idx    <= row_base + COLS_W;
                        clearing   <= 1'b1;
                        clear_full <= 1'b0;
                        state      <= S_CLEAR;
`else
                        state <= S_IDLE;
`endif
                    end else if (ch_q == 8'h0C) begin
                        idx        <= 11'd0;
                        end_idx    <= CELLS;
                        clearing   <= 1'b1;
                        clear_full <= 1'b1;
                        state      <= S_CLEAR;
                    end else begin
                        state <= S_IDLE;
                    end
                end

                S_WR_LO: begin
                    if (bus.mmio_done) begin
                        req_r     <= 1'b0;
                        after_gap <= S_WR_HI;
                        state     <= S_GAP;
                    end
                end

                // The attribute write reuses the ASCII address + 1, so CLEAR and
                // printable characters share the same two-write path.
                S_GAP: begin
                    state <= after_gap;
                    if (after_gap == S_WR_HI) begin
                        addr_r <= addr_r + 16'd1;
                        data_r <= attr_q;
                        req_r  <= 1'b1;
                    end
                end

                S_WR_HI: begin
                    if (bus.mmio_done) begin
                        req_r     <= 1'b0;
                        after_gap <= clearing ? S_CLEAR : S_ADVANCE;
                        state     <= S_GAP;
                    end
                end

                S_ADVANCE: begin
                    if (col == COL_LAST) begin
                        col <= 6'd0;
                        row <= row_next;
`ifdef LCD_CONSOLE_CLEAR_ROW_EN
                        idx        <= row_base;
                        end_idx    <= row_base + COLS_W;
                        clearing   <= 1'b1;
                        clear_full <= 1'b0;
                        state      <= S_CLEAR;
`else
                        state <= S_IDLE;
`endif
                    end else begin
                        col   <= col + 6'd1;
                        state <= S_IDLE;
                    end
                end

                S_CLEAR: begin
                    if (idx == end_idx) begin
                        clearing <= 1'b0;
                        col      <= 6'd0;
                        if (clear_full) begin
                            row <= 5'd0;
                        end
                        state <= S_IDLE;
                    end else begin
                        addr_r <= cell_addr(idx);
                        data_r <= 8'h20;
                        req_r  <= 1'b1;
                        idx    <= idx + 11'd1;
                        state  <= S_WR_LO;
                    end
                end

                default: begin
                    req_r <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_text_console.sv
// Directed bench for lcd_text_console: vector table of single bytes plus multi-cycle
// sequences for line wrap, full clear, reset abort and a slow MMIO acknowledge.
module tb_lcd_text_console;
    localparam logic [15:0] BASE = 16'h4000;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    lcd_text_console_if bus();
    logic [5:0] cursor_col;
    logic [4:0] cursor_row;
    logic       busy;

    lcd_text_console #(.COLS(60), .ROWS(17), .BASE_ADDR(BASE)) dut (
        .clock      (clock),
        .reset      (reset),
        .bus        (bus),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row),
        .busy       (busy)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic ack = 1'b0;
    logic glitch = 1'b0;
    bit   glitch_en = 1'b0;
    int   delay = 0;
    int   wcnt = 0;
    logic        hold_v = 1'b0;
    logic [15:0] hold_a = '0;
    logic [7:0]  hold_d = '0;
    logic [15:0] log_a[$];
    logic [7:0]  log_d[$];

    assign bus.mmio_done = ack | glitch;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // LCD model: acknowledges after `delay` waiting cycles, logs each completed write,
    // checks that a pending request holds address/data, and optionally pulses done while idle.
    always @(negedge clock) begin
        if (bus.mmio_req && hold_v) begin
            check("mmio_addr_stable", bus.mmio_addr, hold_a);
            check("mmio_data_stable", bus.mmio_data, hold_d);
        end
        if (ack) begin
            ack = 1'b0;
            wcnt = 0;
            hold_v = 1'b0;
        end else if (bus.mmio_req) begin
            if (wcnt >= delay) begin
                ack = 1'b1;
                log_a.push_back(bus.mmio_addr);
                log_d.push_back(bus.mmio_data);
                hold_v = 1'b0;
            end else begin
                wcnt++;
                hold_v = 1'b1;
                hold_a = bus.mmio_addr;
                hold_d = bus.mmio_data;
            end
        end else begin
            wcnt = 0;
            hold_v = 1'b0;
        end
        glitch = glitch_en && !bus.mmio_req && !glitch;
    end

    task automatic clear_log();
        log_a.delete();
        log_d.delete();
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        clear_log();
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        while (busy && n < budget) begin
            @(negedge clock);
            n++;
        end
        if (busy) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: still busy after %0d cycles", name, budget);
        end
    endtask

    task automatic send(input logic [7:0] c, input logic [7:0] a);
        int n = 0;
        @(negedge clock);
        bus.ch_data  = c;
        bus.attr     = a;
        bus.ch_valid = 1'b1;
        while (!bus.ch_ready && n < 1000) begin
            @(negedge clock);
            n++;
        end
        if (!bus.ch_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: ch_ready got 0, expected 1");
            bus.ch_valid = 1'b0;
            return;
        end
        @(negedge clock);
        bus.ch_valid = 1'b0;
        check("ch_ready_after_accept", bus.ch_ready, 1'b0);
    endtask

    task automatic put(input logic [7:0] c, input logic [7:0] a, input int budget);
        send(c, a);
        wait_idle(budget, "idle_timeout");
    endtask

    typedef struct {
        logic [7:0] ch;
        logic [7:0] at;
        int         nwr;
        int         off;
        logic [5:0] col;
        logic [4:0] row;
    } vec_t;

    vec_t vt[9];

`ifdef LCD_CONSOLE_CLEAR_ROW_EN
    localparam int ROW_FILL = 120;
`else
    localparam int ROW_FILL = 0;
`endif

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int snap;
        int errs;
        int accepts;
        int ready_hi;
        int n;
        int last;

        bus.ch_data  = 8'h00;
        bus.ch_valid = 1'b0;
        bus.attr     = 8'h00;

        vt[0] = '{ch: 8'h41, at: 8'h1F, nwr: 2, off: 0,   col: 6'd1, row: 5'd0};
        vt[1] = '{ch: 8'h62, at: 8'h2E, nwr: 2, off: 2,   col: 6'd2, row: 5'd0};
        vt[2] = '{ch: 8'h0D, at: 8'h00, nwr: 0, off: 0,   col: 6'd0, row: 5'd0};
        vt[3] = '{ch: 8'h0A, at: 8'h00, nwr: ROW_FILL, off: 0, col: 6'd0, row: 5'd1};
        vt[4] = '{ch: 8'h7E, at: 8'h34, nwr: 2, off: 120, col: 6'd1, row: 5'd1};
        vt[5] = '{ch: 8'h20, at: 8'h00, nwr: 2, off: 122, col: 6'd2, row: 5'd1};
        vt[6] = '{ch: 8'h7F, at: 8'h55, nwr: 0, off: 0,   col: 6'd2, row: 5'd1};
        vt[7] = '{ch: 8'h1F, at: 8'h55, nwr: 0, off: 0,   col: 6'd2, row: 5'd1};
        vt[8] = '{ch: 8'h0D, at: 8'h00, nwr: 0, off: 0,   col: 6'd0, row: 5'd1};

        repeat (3) @(negedge clock);
        check("rst_ch_ready", bus.ch_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_mmio_req", bus.mmio_req, 1'b0);
        check("rst_mmio_addr", bus.mmio_addr, 16'h0000);
        check("rst_mmio_data", bus.mmio_data, 8'h00);
        check("rst_cursor", {cursor_row, cursor_col}, 11'd0);
        reset = 1'b0;

        for (int i = 0; i < 9; i++) begin
            clear_log();
            put(vt[i].ch, vt[i].at, 2000);
            check("vec_write_count", log_a.size(), vt[i].nwr);
            if (vt[i].nwr == 2 && log_a.size() == 2) begin
                check("vec_lo_addr", log_a[0], BASE + 16'(vt[i].off));
                check("vec_lo_data", log_d[0], vt[i].ch);
                check("vec_hi_addr", log_a[1], BASE + 16'(vt[i].off + 1));
                check("vec_hi_data", log_d[1], vt[i].at);
            end
            check("vec_col", cursor_col, vt[i].col);
            check("vec_row", cursor_row, vt[i].row);
        end

        // Sixty characters fill row 0 and auto-wrap to row 1.
        do_reset();
        for (int i = 0; i < 60; i++) put(8'h78, 8'h07, 2000);
        check("line_write_count", log_a.size(), 120 + ROW_FILL);
        if (log_a.size() >= 120) begin
            check("line_last_char_addr", log_a[118], BASE + 16'd118);
            check("line_last_char_data", log_d[118], 8'h78);
            last = log_a.size() - 1;
            check("line_final_addr", log_a[last], BASE + 16'(119 + ROW_FILL));
            check("line_final_data", log_d[last], 8'h07);
        end
        check("line_cursor", {cursor_row, cursor_col}, {5'd1, 6'd0});

        // LF on the last row wraps to the top.
        do_reset();
        for (int i = 0; i < 16; i++) put(8'h0A, 8'h00, 2000);
        check("lf16_cursor", {cursor_row, cursor_col}, {5'd16, 6'd0});
        for (int i = 0; i < 5; i++) put(8'h79, 8'h07, 2000);
        check("pre_lf_cursor", {cursor_row, cursor_col}, {5'd16, 6'd5});
        clear_log();
        put(8'h0A, 8'h00, 2000);
        check("lf_wrap_cursor", {cursor_row, cursor_col}, {5'd0, 6'd0});
        check("lf_wrap_writes", log_a.size(), ROW_FILL);
        if (log_a.size() > 0) check("lf_wrap_last_addr", log_a[log_a.size() - 1], BASE + 16'd119);

        // Character in the bottom-right cell wraps the cursor to (0,0).
        for (int i = 0; i < 16; i++) put(8'h0A, 8'h00, 2000);
        for (int i = 0; i < 59; i++) put(8'h77, 8'h07, 2000);
        check("corner_pre_cursor", {cursor_row, cursor_col}, {5'd16, 6'd59});
        clear_log();
        put(8'h57, 8'h61, 2000);
        check("corner_writes", log_a.size(), 2 + ROW_FILL);
        if (log_a.size() >= 2) begin
            check("corner_lo_addr", log_a[0], BASE + 16'd2038);
            check("corner_lo_data", log_d[0], 8'h57);
            check("corner_hi_addr", log_a[1], BASE + 16'd2039);
            check("corner_hi_data", log_d[1], 8'h61);
        end
        check("corner_cursor", {cursor_row, cursor_col}, {5'd0, 6'd0});

        // Form feed clears every cell.
        put(8'h51, 8'h12, 2000);
        clear_log();
        put(8'h0C, 8'h5A, 20000);
        check("ff_write_count", log_a.size(), 2040);
        errs = 0;
        for (int i = 0; i < log_a.size() && i < 2040; i++) begin
            if (log_a[i] !== BASE + 16'(i)) errs++;
            if (log_d[i] !== ((i % 2 == 1) ? 8'h5A : 8'h20)) errs++;
        end
        check("ff_content_errors", errs, 0);
        check("ff_cursor", {cursor_row, cursor_col}, {5'd0, 6'd0});

        // Reset in the middle of a clear aborts it.
        put(8'h41, 8'h11, 2000);
        clear_log();
        send(8'h0C, 8'h33);
        n = 0;
        while (log_a.size() < 500 && n < 20000) begin
            @(negedge clock);
            n++;
        end
        reset = 1'b1;
        @(negedge clock);
        check("abort_mmio_req", bus.mmio_req, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_ch_ready", bus.ch_ready, 1'b1);
        check("abort_cursor", {cursor_row, cursor_col}, {5'd0, 6'd0});
        snap = log_a.size();
        check("abort_writes_in_range", (snap >= 500 && snap <= 502), 1'b1);
        reset = 1'b0;
        repeat (50) @(negedge clock);
        check("abort_no_more_writes", log_a.size(), snap);

        // Slow acknowledge, spurious done pulses, and ch_valid toggling while busy.
        do_reset();
        delay = 7;
        glitch_en = 1'b1;
        accepts = 0;
        ready_hi = 0;
        @(negedge clock);
        bus.ch_data  = 8'h5A;
        bus.attr     = 8'h4B;
        bus.ch_valid = 1'b1;
        if (bus.ch_valid && bus.ch_ready) accepts++;
        @(negedge clock);
        n = 0;
        while (busy && n < 500) begin
            bus.ch_valid = ~bus.ch_valid;
            bus.ch_data  = 8'h0C;
            if (bus.ch_ready) ready_hi++;
            if (bus.ch_valid && bus.ch_ready) accepts++;
            @(negedge clock);
            n++;
        end
        bus.ch_valid = 1'b0;
        check("slow_still_busy", busy, 1'b0);
        check("slow_accepts", accepts, 1);
        check("slow_ready_while_busy", ready_hi, 0);
        check("slow_write_count", log_a.size(), 2);
        if (log_a.size() == 2) begin
            check("slow_lo_addr", log_a[0], BASE);
            check("slow_lo_data", log_d[0], 8'h5A);
            check("slow_hi_addr", log_a[1], BASE + 16'd1);
            check("slow_hi_data", log_d[1], 8'h4B);
        end
        check("slow_cursor", {cursor_row, cursor_col}, {5'd0, 6'd1});
        delay = 0;
        glitch_en = 1'b0;
        repeat (5) @(negedge clock);
        check("slow_no_extra_writes", log_a.size(), 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
